// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel fractional clock-enable generator with a lock-gated start-up sequencer.
// Define CLK_EN_GEN_HALF_EN to enable the half-scale (180 degree) enables on cen_n.
module clk_en_gen #(
  parameter int          NUM_CH   = 2,
  parameter int          ACC_W    = 16,
  parameter int          LOCK_DLY = 64,
  parameter int unsigned DEF_INC  = 0,
  localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] cen,
  output logic [NUM_CH-1:0] cen_n,
  output logic              ready
);

  localparam int                CNT_W    = (LOCK_DLY > 1) ? $clog2(LOCK_DLY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_DLY - 1);
  localparam logic [ACC_W-1:0]  INC_RST  = ACC_W'(DEF_INC);
  localparam int unsigned       NCH_U    = NUM_CH;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           ready_q;
  logic [NUM_CH-1:0][ACC_W-1:0]   inc_q, inc_d;
  logic [NUM_CH-1:0][ACC_W-1:0]   phase_q, phase_d;
  logic [NUM_CH-1:0][ACC_W-1:0]   acc_q, acc_d;
  logic [NUM_CH-1:0]              cen_q, cen_d;
  logic [ACC_W:0]                 sum;
  logic                           wr_ok;
  logic                           enter_run;
  logic                           run_go;
  logic [31:0]                    ch_ext;

  // Start-up sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (locked) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (!locked) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  assign ch_ext    = 32'(cfg_ch);
  assign wr_ok     = cfg_we && (ch_ext < NCH_U);
  assign enter_run = (state_q != RUN) && (state_d == RUN);
  assign run_go    = (state_q == RUN) && (state_d == RUN);

`ifdef CLK_EN_GEN_HALF_EN
  logic [NUM_CH-1:0] cen_n_q, cen_n_d;
`endif

  // A config write overrides both the RUN-entry phase load and the accumulate step,
  // so the written channel's carry for that cycle is dropped.
  always_comb begin
    inc_d   = inc_q;
    phase_d = phase_q;
    acc_d   = acc_q;
    cen_d   = '0;
    sum     = '0;
`ifdef CLK_EN_GEN_HALF_EN
    cen_n_d = '0;
`endif
    for (int unsigned i = 0; i < NCH_U; i++) begin
      sum = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      if (wr_ok && (ch_ext == i)) begin
        inc_d[i]   = cfg_inc;
        phase_d[i] = cfg_phase;
        acc_d[i]   = cfg_phase;
      end else if (enter_run) begin
        acc_d[i] = phase_q[i];
      end else if (run_go) begin
        acc_d[i] = sum[ACC_W-1:0];
        cen_d[i] = sum[ACC_W];
`ifdef CLK_EN_GEN_HALF_EN
        cen_n_d[i] = sum[ACC_W-1] & ~acc_q[i][ACC_W-1];
`endif
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      inc_q   <= {NUM_CH{INC_RST}};
      phase_q <= '0;
      acc_q   <= '0;
      cen_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == RUN);
      inc_q   <= inc_d;
      phase_q <= phase_d;
      acc_q   <= acc_d;
      cen_q   <= cen_d;
    end
  end

`ifdef CLK_EN_GEN_HALF_EN
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      cen_n_q <= '0;
    end else begin
      cen_n_q <= cen_n_d;
    end
  end
  assign cen_n = cen_n_q;
`else
  assign cen_n = '0;
`endif

  assign cen   = cen_q;
  assign ready = ready_q;

endmodule

// File: doc/clk_en_gen.md
# clk_en_gen

Multi-channel fractional clock-enable generator driven by the core's PLL output clock. It produces NUM_CH independent single-cycle enables whose rates are set at run time by phase-accumulator increments, so one PLL frequency can serve CPU, sound and video domains. A lock-gated start-up sequencer holds all enables low until the PLL `locked` flag has been stable. It restarts cleanly if lock is lost.

## Interface
Parameters:
- `NUM_CH`, 2, number of enable channels (1..8).
- `ACC_W`, 16, accumulator and increment width in bits.
- `LOCK_DLY`, 64, consecutive cycles of `locked` high required before enables run (≥1).
- `DEF_INC`, 0, reset value of every channel increment (0 = channel disabled).

Ports:
- `refclk`  in  1  the single clock, normally the PLL output. One clock; reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset.
- `locked`  in  1  PLL lock flag, already synchronised to `refclk`.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_ch`  in  max(1,clog2(NUM_CH))  channel index for the write.
- `cfg_inc`  in  ACC_W  increment value for the write.
- `cfg_phase`  in  ACC_W  accumulator load value for the write.
- `cen`  out  NUM_CH  per-channel enable, one-cycle pulses.
- `cen_n`  out  NUM_CH  per-channel mid-period enable (see Configuration).
- `ready`  out  1  high while in RUN.

## Operation
- FSM states:
  - WAIT_LOCK (reset state): stays here while `locked`=0. Moves to SETTLE, with the counter cleared, when `locked`=1.
  - SETTLE: counts cycles with `locked`=1. Returns to WAIT_LOCK when `locked`=0. Moves to RUN when count = LOCK_DLY-1.
  - RUN: returns to WAIT_LOCK when `locked`=0.
- Per channel: registers `inc_i` and `phase_i`, and accumulator `acc_i`.
- On the transition into RUN, every `acc_i` is loaded with `phase_i`.
- Each RUN cycle: {carry, sum} = acc_i + inc_i, computed at ACC_W+1 bits. Then `acc_i`<=sum (modulo 2^ACC_W) and `cen[i]`<=carry.
- Enable rate is f_refclk·inc/2^ACC_W. With inc=0, `cen[i]` stays 0.
- Outside RUN: accumulators hold, and `cen`/`cen_n` are forced 0.
- Config write (`cfg_we`=1, `cfg_ch`<NUM_CH), accepted in any state: `inc`<=`cfg_inc`, `phase`<=`cfg_phase`, `acc`<=`cfg_phase`. That channel's `cen`/`cen_n` are 0 on the next cycle; the carry of that cycle is discarded.
- Writes with `cfg_ch`≥NUM_CH are ignored.
- Write coinciding with loss of lock: the registers update, and the FSM goes to WAIT_LOCK.
- Reset: FSM=WAIT_LOCK, counter=0, `inc_i`=DEF_INC, `phase_i`=0, `acc_i`=0, `cen`=0, `cen_n`=0, `ready`=0.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- `ready` rises on the first RUN cycle R, which is LOCK_DLY+1 cycles after `locked` first samples high in WAIT_LOCK. `ready` falls the cycle after `locked` samples low.
- A channel with phase 0 and inc=2^ACC_W/N pulses `cen` in cycles R+N, R+2N, and so on; each pulse is exactly 1 cycle wide.
- Mid-run config write in cycle W: the new accumulator value is live from W+1. The first possible pulse is at W+2.
- Wrap-around: the accumulator wraps silently. The fractional remainder is kept, so the long-term rate is exact with zero drift.
- Loss of lock mid-period: `cen` is 0 from the next cycle. The accumulator phase restarts from `phase_i` on re-entry to RUN.

## Configuration
- Macro `CLK_EN_GEN_HALF_EN` defined:
  - `cen_n[i]`<=1 in a RUN cycle where sum[ACC_W-1]=1 and acc_i[ACC_W-1]=0, i.e. the accumulator crosses half scale. This gives a 180° enable for dual-edge logic.
  - Valid only when inc ≤ 2^(ACC_W-1). Larger increments give undefined `cen_n` but correct `cen`.
- Macro undefined: the half-scale detect logic is removed, and `cen_n` is tied to 0. The port is still present.

## Test plan
- Reset then lock: `rst_n`=0 for 4 cycles, `locked`=1 from then on, LOCK_DLY=64 -> `ready`=0 for 65 cycles then 1; `cen`=0 throughout with DEF_INC=0.
- Integer divide: ch0 inc=0x4000, phase=0 (ACC_W=16) -> `cen[0]` at R+4, R+8, R+12…, each pulse 1 cycle wide. With the macro, `cen_n[0]` at R+2, R+6, R+10…
- Fractional rate: ch1 inc=0x5556 over 3000 RUN cycles -> exactly 1000 pulses ±1, spacing 3 cycles. ch0 is unaffected.
- Lock glitch: `locked` low for 1 cycle during SETTLE at count 30 -> the count restarts. The same glitch in RUN -> `ready` and `cen` go 0 the next cycle; RUN resumes LOCK_DLY+1 cycles after `locked` returns, with the accumulator at `phase`.
- Mid-run write: ch0 inc=0x4000 running; write inc=0x8000, phase=0xC000 in cycle W -> `cen[0]`=0 at W+1, pulse at W+2, then every 2 cycles.
- Invalid write: `cfg_ch`=NUM_CH with `cfg_we`=1 -> all channels' pulse timing unchanged.
